// File: rtl/soc_system_sph_pio_pkg.sv
// Shared register map and capture-edge encodings for the HPS key input PIO.
// Imported by the debounce leaf and the PIO top level.
package soc_system_sph_pio_pkg;

   localparam logic [1:0] ADDR_DATA         = 2'd0;
   localparam logic [1:0] ADDR_IRQ_MASK     = 2'd2;
   localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

   typedef enum logic [1:0] {
      EDGE_RISING  = 2'd0,
      EDGE_FALLING = 2'd1,
      EDGE_ANY     = 2'd2
   } edge_type_e;

endpackage

// File: rtl/soc_system_sph_key_pio_if.sv
// Avalon-MM slave bus of the key PIO: address/strobe/data in, registered readdata out.
// Fixed read latency of 1; there is no waitrequest, so the slave never stalls.
interface soc_system_sph_key_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/soc_system_sph_pio_debounce.sv
// One input line: two-flop synchronizer followed by a stability counter.
// A stable change reaches deb 2 + DEBOUNCE_CYCLES cycles after it appears at din.
module soc_system_sph_pio_debounce #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RESET_VALUE     = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic deb
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= RESET_VALUE;
         sync2 <= RESET_VALUE;
         deb   <= RESET_VALUE;
         cnt   <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         // Any return to the accepted level restarts the stability window.
         if (sync2 == deb) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            deb <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/soc_system_sph_key_pio.sv
// Key/switch input PIO: debounced DATA, IRQ_MASK, W1C EDGE_CAPTURE and a registered level irq.
// readdata is registered every cycle (latency 1); writes take effect at once, never stalled.
module soc_system_sph_key_pio
   import soc_system_sph_pio_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] IN_RESET_VALUE  = {WIDTH{1'b1}}
) (
   input  logic                      clk,
   input  logic                      reset,
   soc_system_sph_key_pio_if.slave   bus,
   input  logic [WIDTH-1:0]          in_port,
   output logic                      irq
);
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_d;
   logic [WIDTH-1:0] ec;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_sel;
   logic [WIDTH-1:0] clr;
   logic [31:0]      rd_mux;
   logic             wr;
   logic             unused_wdata;

   assign unused_wdata = ^bus.writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_line
      soc_system_sph_pio_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VALUE     (IN_RESET_VALUE[i])
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .din   (in_port[i]),
         .deb   (deb[i])
      );
   end

   assign wr = bus.chipselect & ~bus.write_n;

   always_comb begin
      rise     = deb & ~deb_d;
      fall     = ~deb & deb_d;
      edge_sel = '0;
      if (EDGE_TYPE == int'(EDGE_RISING)) begin
         edge_sel = rise;
      end else if (EDGE_TYPE == int'(EDGE_FALLING)) begin
         edge_sel = fall;
      end else begin
         edge_sel = rise | fall;
      end
      clr = '0;
      if (wr && bus.address == ADDR_EDGE_CAPTURE) begin
         clr = bus.writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_DATA:         rd_mux[WIDTH-1:0] = deb;
         ADDR_IRQ_MASK:     rd_mux[WIDTH-1:0] = irq_mask;
         ADDR_EDGE_CAPTURE: rd_mux[WIDTH-1:0] = ec;
         default:           rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         deb_d        <= IN_RESET_VALUE;
         ec           <= '0;
         irq_mask     <= '0;
         irq          <= 1'b0;
         bus.readdata <= '0;
      end else begin
         deb_d <= deb;
         // A new edge outranks a simultaneous clear of the same bit.
         ec    <= (ec & ~clr) | edge_sel;
         if (wr && bus.address == ADDR_IRQ_MASK) begin
            irq_mask <= bus.writedata[WIDTH-1:0];
         end
         irq          <= |(ec & irq_mask);
         bus.readdata <= rd_mux;
      end
   end
endmodule

// File: tb/tb_soc_system_sph_key_pio.sv
// Directed bench: a falling-edge PIO and an any-edge PIO share the same stimulus.
module tb_soc_system_sph_key_pio;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic        irq;
   logic        irq_any;
   int          checks   = 0;
   int          failures = 0;

   soc_system_sph_key_pio_if bus ();
   soc_system_sph_key_pio_if bus_any ();

   assign bus.address        = address;
   assign bus.chipselect     = chipselect;
   assign bus.write_n        = write_n;
   assign bus.writedata      = writedata;
   assign bus_any.address    = address;
   assign bus_any.chipselect = chipselect;
   assign bus_any.write_n    = write_n;
   assign bus_any.writedata  = writedata;

   soc_system_sph_key_pio #(
      .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IN_RESET_VALUE(4'hF)
   ) u_dut (
      .clk(clk), .reset(reset), .bus(bus), .in_port(in_port), .irq(irq)
   );

   soc_system_sph_key_pio #(
      .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IN_RESET_VALUE(4'hF)
   ) u_dut_any (
      .clk(clk), .reset(reset), .bus(bus_any), .in_port(in_port), .irq(irq_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr_start(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
   endtask

   task automatic wr_end();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   initial begin
      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 4'hF;
      step(3);
      check("reset_readdata", bus.readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      reset = 1'b0;

      // Register reads after reset
      address = 2'd0; step(1);
      check("rst_data", bus.readdata, 32'hF);
      address = 2'd2; step(1);
      check("rst_mask", bus.readdata, 32'h0);
      address = 2'd3; step(1);
      check("rst_ec", bus.readdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);

      // Bit 0 falls: deb updates 6 edges later, readdata one edge after that
      in_port = 4'hE; address = 2'd0;
      step(6);
      check("data_before_deb", bus.readdata, 32'hF);
      step(1);
      check("data_after_deb", bus.readdata, 32'hE);
      address = 2'd3; step(1);
      check("ec_fall0", bus.readdata, 32'h1);
      check("ec_fall0_any", bus_any.readdata, 32'h1);
      check("irq_masked", {31'b0, irq}, 32'h0);

      // 3-cycle glitch on bit 1 must be rejected
      in_port = 4'hC; step(3);
      in_port = 4'hE; step(10);
      check("glitch_ec", bus.readdata, 32'h1);
      address = 2'd0; step(1);
      check("glitch_data", bus.readdata, 32'hE);
      check("glitch_irq", {31'b0, irq}, 32'h0);

      // Unmask bit 0: irq follows one edge after the mask write
      wr_start(2'd2, 32'h1); step(1); wr_end();
      check("irq_same_edge_as_mask", {31'b0, irq}, 32'h0);
      step(1);
      check("irq_after_mask", {31'b0, irq}, 32'h1);
      address = 2'd2; step(1);
      check("mask_readback", bus.readdata, 32'h1);

      // W1C bit 0: irq drops the edge after the clear
      wr_start(2'd3, 32'h1); step(1); wr_end();
      check("irq_at_clear_edge", {31'b0, irq}, 32'h1);
      address = 2'd3; step(1);
      check("irq_after_clear", {31'b0, irq}, 32'h0);
      check("ec_after_clear", bus.readdata, 32'h0);

      // Writes to addresses 0 and 1 are ignored; address 1 reads 0
      wr_start(2'd0, 32'h0); step(1); wr_end();
      wr_start(2'd1, 32'hF); step(1); wr_end();
      check("addr1_reads_zero", bus.readdata, 32'h0);
      address = 2'd0; step(1);
      check("data_unchanged_by_write", bus.readdata, 32'hE);

      // Bit 2 falls on the same edge as a W1C of bit 2: edge wins
      in_port = 4'hA;
      step(6);
      wr_start(2'd3, 32'h4); step(1); wr_end();
      address = 2'd3; step(1);
      check("edge_beats_clear", bus.readdata, 32'h4);
      check("edge_beats_clear_any", bus_any.readdata, 32'h4);
      check("irq_bit2_masked", {31'b0, irq}, 32'h0);
      wr_start(2'd3, 32'h4); step(1); wr_end();
      address = 2'd3; step(1);
      check("ec2_cleared", bus.readdata, 32'h0);

      // Bits 0 and 2 rise: ignored by falling PIO, captured by any-edge PIO
      in_port = 4'hF;
      step(8);
      check("rise_ignored", bus.readdata, 32'h0);
      check("rise_captured_any", bus_any.readdata, 32'h5);
      check("irq_rise_fall_dut", {31'b0, irq}, 32'h0);
      check("irq_rise_any_dut", {31'b0, irq_any}, 32'h1);

      // Reset in the middle of a bit-3 debounce
      in_port = 4'h7; step(3);
      reset = 1'b1; step(1); reset = 1'b0;
      check("midrst_readdata", bus.readdata, 32'h0);
      check("midrst_irq_any", {31'b0, irq_any}, 32'h0);
      address = 2'd0; step(1);
      check("midrst_data", bus.readdata, 32'hF);
      address = 2'd2; step(1);
      check("midrst_mask", bus_any.readdata, 32'h0);
      address = 2'd3; step(1);
      check("midrst_ec", bus_any.readdata, 32'h0);
      step(8);
      check("midrst_recapture", bus.readdata, 32'h8);
      address = 2'd0; step(1);
      check("midrst_redebounced", bus.readdata, 32'h7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
